// File: rtl/cpu_checker_pkg.sv
// Shared types and constants for the parametrised CPU trace checker.
package cpu_checker_pkg;

    typedef enum logic [3:0] {
        IDLE, TIME, PC, COLON_SP, REG, ADDR, PRE_SP, LT, POST_SP, DATA, DONE_REG, DONE_MEM
    } state_t;

    localparam logic [7:0] CH_CARET  = 8'h5E;
    localparam logic [7:0] CH_AT     = 8'h40;
    localparam logic [7:0] CH_COLON  = 8'h3A;
    localparam logic [7:0] CH_DOLLAR = 8'h24;
    localparam logic [7:0] CH_STAR   = 8'h2A;
    localparam logic [7:0] CH_LT     = 8'h3C;
    localparam logic [7:0] CH_EQ     = 8'h3D;
    localparam logic [7:0] CH_HASH   = 8'h23;
    localparam logic [7:0] CH_SPACE  = 8'h20;

    localparam logic [31:0] PC_LO   = 32'h0000_3000;
    localparam logic [31:0] PC_HI   = 32'h0000_4fff;
    localparam logic [31:0] ADDR_HI = 32'h0000_2fff;
    localparam logic [13:0] REG_MAX = 14'd31;

    localparam logic [1:0] FMT_NONE = 2'd0;
    localparam logic [1:0] FMT_REG  = 2'd1;
    localparam logic [1:0] FMT_MEM  = 2'd2;

endpackage

// File: rtl/cpu_checker_ext_char_classify.sv
// Classifies one ASCII character as decimal / lowercase-hex digit and yields its value.
module char_classify (
    input  logic [7:0] char,
    output logic       is_dec,
    output logic       is_hex,
    output logic [3:0] nibble
);
    logic is_lower;

    always_comb begin
        is_dec   = (char >= 8'h30) && (char <= 8'h39);
        is_lower = (char >= 8'h61) && (char <= 8'h66);
        is_hex   = is_dec || is_lower;
        nibble   = '0;
        if (is_dec)
            nibble = char[3:0];
        else if (is_lower)
            nibble = char[3:0] + 4'd9;
    end
endmodule

// File: rtl/cpu_checker_ext.sv
// Character-serial trace record parser: reports record type and semantic errors
// for one cycle after the closing '#'.
module cpu_checker_ext
    import cpu_checker_pkg::*;
#(
    parameter int TIME_DIGITS = 4,
    parameter int HEX_DIGITS  = 8,
    parameter int REG_DIGITS  = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] freq,
    input  logic [7:0]  char,
    output logic [1:0]  format_type,
    output logic [3:0]  error_code
);
    localparam logic [3:0] TD = 4'(TIME_DIGITS);
    localparam logic [3:0] HD = 4'(HEX_DIGITS);
    localparam logic [3:0] RD = 4'(REG_DIGITS);

    state_t      state;
    logic [3:0]  cnt;
    logic [26:0] time_acc;
    logic [13:0] reg_acc;
    logic [31:0] pc_acc;
    logic [31:0] addr_acc;
    logic        is_mem;
    logic [1:0]  fmt_q;
    logic [3:0]  err_q;
    logic [3:0]  err_next;
    logic [15:0] half_period;
    logic        is_dec;
    logic        is_hex;
    logic [3:0]  nibble;

    char_classify u_classify (
        .char   (char),
        .is_dec (is_dec),
        .is_hex (is_hex),
        .nibble (nibble)
    );

    always_comb begin
        half_period = freq >> 1;
        err_next    = '0;
        err_next[0] = (time_acc % {11'b0, half_period}) != '0;
        err_next[1] = (pc_acc < PC_LO) || (pc_acc > PC_HI) || (pc_acc[1:0] != 2'b00);
        err_next[2] = is_mem && ((addr_acc > ADDR_HI) || (addr_acc[1:0] != 2'b00));
        err_next[3] = !is_mem && (reg_acc > REG_MAX);
    end

    // Outputs are registered on the '#' edge itself, so they track the DONE_* state exactly.
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            cnt      <= '0;
            time_acc <= '0;
            reg_acc  <= '0;
            pc_acc   <= '0;
            addr_acc <= '0;
            is_mem   <= 1'b0;
            fmt_q    <= FMT_NONE;
            err_q    <= '0;
        end else begin
            fmt_q <= FMT_NONE;
            err_q <= '0;
            if (char == CH_CARET) begin
                state    <= TIME;
                cnt      <= '0;
                time_acc <= '0;
                reg_acc  <= '0;
                pc_acc   <= '0;
                addr_acc <= '0;
                is_mem   <= 1'b0;
            end else begin
                case (state)
                    TIME:
                        if (is_dec && cnt < TD) begin
                            time_acc <= time_acc * 27'd10 + {23'b0, nibble};
                            cnt      <= cnt + 4'd1;
                        end else if (char == CH_AT && cnt != '0) begin
                            state <= PC;
                            cnt   <= '0;
                        end else
                            state <= IDLE;
                    PC:
                        if (is_hex && cnt < HD) begin
                            pc_acc <= {pc_acc[27:0], nibble};
                            cnt    <= cnt + 4'd1;
                        end else if (char == CH_COLON && cnt == HD)
                            state <= COLON_SP;
                        else
                            state <= IDLE;
                    COLON_SP:
                        if (char == CH_DOLLAR) begin
                            state <= REG;
                            cnt   <= '0;
                        end else if (char == CH_STAR) begin
                            state  <= ADDR;
                            cnt    <= '0;
                            is_mem <= 1'b1;
                        end else if (char != CH_SPACE)
                            state <= IDLE;
                    REG:
                        if (is_dec && cnt < RD) begin
                            reg_acc <= reg_acc * 14'd10 + {10'b0, nibble};
                            cnt     <= cnt + 4'd1;
                        end else if (char == CH_SPACE && cnt != '0)
                            state <= PRE_SP;
                        else if (char == CH_LT && cnt != '0)
                            state <= LT;
                        else
                            state <= IDLE;
                    ADDR:
                        if (is_hex && cnt < HD) begin
                            addr_acc <= {addr_acc[27:0], nibble};
                            cnt      <= cnt + 4'd1;
                        end else if (char == CH_SPACE && cnt == HD)
                            state <= PRE_SP;
                        else if (char == CH_LT && cnt == HD)
                            state <= LT;
                        else
                            state <= IDLE;
                    PRE_SP:
                        if (char == CH_LT)
                            state <= LT;
                        else if (char != CH_SPACE)
                            state <= IDLE;
                    LT:
                        state <= (char == CH_EQ) ? POST_SP : IDLE;
                    POST_SP:
                        if (is_hex) begin
                            state <= DATA;
                            cnt   <= 4'd1;
                        end else if (char != CH_SPACE)
                            state <= IDLE;
                    DATA:
                        if (is_hex && cnt < HD)
                            cnt <= cnt + 4'd1;
                        else if (char == CH_HASH && cnt == HD) begin
                            state <= is_mem ? DONE_MEM : DONE_REG;
                            fmt_q <= is_mem ? FMT_MEM : FMT_REG;
                            err_q <= err_next;
                        end else
                            state <= IDLE;
                    default:
                        state <= IDLE;
                endcase
            end
        end
    end

    assign format_type = fmt_q;
    assign error_code  = err_q;
endmodule

// File: tb/tb_cpu_checker_ext.sv
// Directed-stream bench for cpu_checker_ext with a string-level record model.
module tb_cpu_checker_ext;
    localparam int TD = 4;
    localparam int HD = 8;
    localparam int RD = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] freq;
    logic [7:0]  ch;
    logic [1:0]  format_type;
    logic [3:0]  error_code;

    int checks = 0;
    int errors = 0;

    cpu_checker_ext #(.TIME_DIGITS(TD), .HEX_DIGITS(HD), .REG_DIGITS(RD)) dut (
        .clk         (clk),
        .reset       (rst),
        .freq        (freq),
        .char        (ch),
        .format_type (format_type),
        .error_code  (error_code)
    );

    always #5 clk = ~clk;

    function automatic bit dec_c(input logic [7:0] c);
        return c >= 8'h30 && c <= 8'h39;
    endfunction

    function automatic bit hex_c(input logic [7:0] c);
        return dec_c(c) || (c >= 8'h61 && c <= 8'h66);
    endfunction

    function automatic int val_c(input logic [7:0] c);
        return dec_c(c) ? int'(c) - 48 : int'(c) - 87;
    endfunction

    // Whole-record validation of the text since the last '^'.
    function automatic void model_eval(input string s, input int f, output int fmt, output int err);
        int i, n;
        longint unsigned t, pc, ad, rg;
        bit mem;
        logic [7:0] c;
        fmt = 0; err = 0; i = 1; t = 0; pc = 0; ad = 0; rg = 0; mem = 0;
        if (s.len() == 0 || s[0] != "^") return;
        n = 0;
        while (dec_c(s[i])) begin t = t * 10 + val_c(s[i]); i++; n++; end
        if (n < 1 || n > TD || s[i] != "@") return;
        i++;
        for (int k = 0; k < HD; k++) begin
            if (!hex_c(s[i])) return;
            pc = pc * 16 + val_c(s[i]); i++;
        end
        if (s[i] != ":") return;
        i++;
        while (s[i] == " ") i++;
        c = s[i];
        if (c == "$") begin
            i++; n = 0;
            while (dec_c(s[i])) begin rg = rg * 10 + val_c(s[i]); i++; n++; end
            if (n < 1 || n > RD) return;
        end else if (c == "*") begin
            mem = 1; i++;
            for (int k = 0; k < HD; k++) begin
                if (!hex_c(s[i])) return;
                ad = ad * 16 + val_c(s[i]); i++;
            end
        end else return;
        while (s[i] == " ") i++;
        if (s[i] != "<") return;
        i++;
        if (s[i] != "=") return;
        i++;
        while (s[i] == " ") i++;
        for (int k = 0; k < HD; k++) begin
            if (!hex_c(s[i])) return;
            i++;
        end
        if (s[i] != "#" || i != s.len() - 1) return;
        fmt = mem ? 2 : 1;
        if (t % (f / 2) != 0) err |= 1;
        if (pc < 'h3000 || pc > 'h4fff || pc % 4 != 0) err |= 2;
        if (mem && (ad > 'h2fff || ad % 4 != 0)) err |= 4;
        if (!mem && rg > 31) err |= 8;
    endfunction

    string buffer = "";
    int    exp_fmt = 0;
    int    exp_err = 0;
    bit    started = 0;
    logic [5:0] dut_pulses[$];
    logic [5:0] model_pulses[$];

    always @(posedge clk) begin
        started = 1;
        exp_fmt = 0;
        exp_err = 0;
        if (rst) begin
            buffer = "";
        end else if (ch == "^") begin
            buffer = "^";
        end else if (buffer.len() > 0) begin
            buffer = {buffer, " "};
            buffer.putc(buffer.len() - 1, ch);
            if (ch == "#") model_eval(buffer, int'(freq), exp_fmt, exp_err);
        end
        if (exp_fmt != 0) model_pulses.push_back({2'(exp_fmt), 4'(exp_err)});
    end

    always @(negedge clk) begin
        if (started) begin
            checks++;
            if (format_type !== 2'(exp_fmt) || error_code !== 4'(exp_err)) begin
                errors++;
                $display("FAIL cycle_compare t=%0t: got fmt=%0d err=%b, want fmt=%0d err=%b",
                         $time, format_type, error_code, exp_fmt, 4'(exp_err));
            end
            if (format_type != 2'd0) dut_pulses.push_back({format_type, error_code});
        end
    end

    task automatic expect_pulses(input string name, input int n, input logic [5:0] a, input logic [5:0] b);
        logic [5:0] want[2];
        want[0] = a; want[1] = b;
        checks++;
        if (dut_pulses.size() != n) begin
            errors++;
            $display("FAIL %s dut_pulse_count: got %0d, want %0d", name, dut_pulses.size(), n);
        end else
            for (int k = 0; k < n; k++)
                if (dut_pulses[k] !== want[k]) begin
                    errors++;
                    $display("FAIL %s dut_pulse%0d: got fmt=%0d err=%b, want fmt=%0d err=%b",
                             name, k, dut_pulses[k][5:4], dut_pulses[k][3:0], want[k][5:4], want[k][3:0]);
                end
        checks++;
        if (model_pulses.size() != n) begin
            errors++;
            $display("FAIL %s model_pulse_count: got %0d, want %0d", name, model_pulses.size(), n);
        end else
            for (int k = 0; k < n; k++)
                if (model_pulses[k] !== want[k]) begin
                    errors++;
                    $display("FAIL %s model_pulse%0d: got %h, want %h", name, k, model_pulses[k], want[k]);
                end
        dut_pulses.delete();
        model_pulses.delete();
    endtask

    task automatic send(input string s);
        for (int i = 0; i < s.len(); i++) begin
            @(negedge clk);
            ch = s[i];
        end
        repeat (2) begin
            @(negedge clk);
            ch = " ";
        end
        @(negedge clk);
    endtask

    initial begin
        rst = 1'b1; ch = 8'h00; freq = 16'd2;
        repeat (3) @(negedge clk);
        checks++;
        if (format_type !== 2'd0 || error_code !== 4'd0) begin
            errors++;
            $display("FAIL reset_state: got fmt=%0d err=%b, want fmt=0 err=0000", format_type, error_code);
        end
        rst = 1'b0;

        freq = 16'd2;
        send("^123@000030fc: *00000001 <= 89abcdef#");
        expect_pulses("mem_misaligned", 1, {2'd2, 4'b0100}, 6'd0);

        freq = 16'd4;
        send("^10@00003000: $31 <= 0000000a#");
        expect_pulses("reg_ok", 1, {2'd1, 4'b0000}, 6'd0);
        send("^11@00003000: $31 <= 0000000a#");
        expect_pulses("reg_time_err", 1, {2'd1, 4'b0001}, 6'd0);
        send("^10@00005000: $32 <= 0000000a#");
        expect_pulses("reg_pc_reg_err", 1, {2'd1, 4'b1010}, 6'd0);

        freq = 16'd6;
        send("^9@00004ffc:$0<=ffffffff#");
        expect_pulses("pc_upper_edge", 1, {2'd1, 4'b0000}, 6'd0);
        send("^9999@00002ffc:*00002ffc<=00000000#");
        expect_pulses("pc_low_addr_edge", 1, {2'd2, 4'b0010}, 6'd0);

        send("^12345@00003000:$1<=00000000#");
        expect_pulses("five_time_digits", 0, 6'd0, 6'd0);
        send("^1@00003F00:$1<=00000000#");
        expect_pulses("uppercase_pc", 0, 6'd0, 6'd0);
        send("^1@00003000:$1<00000000#");
        expect_pulses("missing_eq", 0, 6'd0, 6'd0);
        send("^1@0003000:$1<=00000000#");
        expect_pulses("seven_pc_digits", 0, 6'd0, 6'd0);
        send("^1@00003000:$12345<=00000000#");
        expect_pulses("five_reg_digits", 0, 6'd0, 6'd0);

        freq = 16'd2;
        send("^12@000^5@00003004:*00000000<=00000000#");
        expect_pulses("restart_mid_record", 1, {2'd2, 4'b0000}, 6'd0);

        send("^2@00003000:*00000100<=00000000#^2@00003000:$5<=00000000#");
        expect_pulses("back_to_back", 2, {2'd2, 4'b0000}, {2'd1, 4'b0000});

        begin
            string s;
            s = "^2@00003000:$5<=0000000";
            for (int i = 0; i < s.len(); i++) begin
                @(negedge clk);
                ch = s[i];
            end
            @(negedge clk);
            rst = 1'b1; ch = "0";
            @(negedge clk);
            rst = 1'b0; ch = "#";
            repeat (2) begin
                @(negedge clk);
                ch = " ";
            end
            @(negedge clk);
        end
        expect_pulses("reset_before_hash", 0, 6'd0, 6'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/cpu_checker_ext.md
# cpu_checker_ext

Parametrised successor to the single-format CPU trace checker. It consumes one ASCII character per clock from the simulator trace stream and recognises register-write and memory-write records. Each record is validated for syntax and for semantic errors: time versus clock frequency, PC range and alignment, address range and alignment, and register index. It sits on the trace-monitor path, after the character source and ahead of the scoreboard that counts record types and errors.

## Interface
- `TIME_DIGITS`, default 4: maximum decimal digits in the time field (1..8).
- `HEX_DIGITS`, default 8: exact hex digit count of the pc, addr and data fields (4..8). Values are zero-extended to 32 bits.
- `REG_DIGITS`, default 4: maximum decimal digits in the register field (1..4).
- `clk` input, 1 bit: single clock, posedge.
- `reset` input, 1 bit: synchronous, active-high. Returns the FSM to `IDLE` and clears all accumulators.
- `freq` input, 16 bits: CPU clock period in trace time units. Even, ≥2, stable for the duration of a record.
- `char` input, 8 bits: ASCII character, sampled every posedge.
- `format_type` output, 2 bits: 0 means no record, 1 means register-write record, 2 means memory-write record. 3 is never driven.
- `error_code` output, 4 bits: bit0 time, bit1 pc, bit2 addr, bit3 reg. Non-zero only while `format_type` ≠ 0.

## Operation
- Record grammar:
  - `^`, then 1..`TIME_DIGITS` decimal digits, then `@`.
  - `HEX_DIGITS` hex digits, then `:`.
  - Zero or more spaces.
  - Either `$` with 1..`REG_DIGITS` decimal digits, or `*` with `HEX_DIGITS` hex digits.
  - Zero or more spaces, then `<=`, then zero or more spaces.
  - `HEX_DIGITS` hex digits, then `#`.
- Hex digits are 0-9 and lowercase a-f only; uppercase letters are a syntax error.
- States: `IDLE`, `TIME`, `PC`, `COLON_SP`, `REG`, `ADDR`, `PRE_SP`, `LT`, `POST_SP`, `DATA`, `DONE_REG`, `DONE_MEM`.
- A digit counter tracks position within each numeric field. Field transitions fire only on the terminator, and only after a legal digit count.
- Any character not permitted by the grammar in the current state sends the FSM to `IDLE`. This includes excess digits.
- `^` in any state, including `IDLE`, `DONE_*` and mid-record, restarts the record: next state `TIME`, accumulators cleared.
- Accumulators:
  - time: decimal, `time = time*10 + d`, 27 bits wide.
  - reg: decimal, 14 bits wide.
  - pc and addr: hex shift-left by 4, 32 bits wide.
  - data is syntax-checked only and not stored.
- Error evaluation happens on the `#` transition into `DONE_*`; results are registered into `err_q`.
  - bit0 = (time mod (freq>>1)) ≠ 0.
  - bit1 = pc < 0x3000, or pc > 0x4fff, or pc[1:0] ≠ 0.
  - bit2 (memory records only) = addr > 0x2fff, or addr[1:0] ≠ 0.
  - bit3 (register records only) = reg > 31.
  - The bit that does not apply to the record type is 0.
- Outputs are Moore, decoded from state:
  - `DONE_REG` gives `format_type` = 1.
  - `DONE_MEM` gives `format_type` = 2.
  - `error_code` = `err_q` in either `DONE_*` state, 0 otherwise.
- From `DONE_*`: `^` goes to `TIME`; any other character goes to `IDLE`.

## Timing
- Reset values: state `IDLE`, `format_type` 0, `error_code` 0, all accumulators 0.
- Latency: `#` sampled at edge N; outputs valid from edge N to edge N+1 (one cycle).
- Back-to-back records are supported: `^` immediately after `#` gives one valid cycle, then parsing resumes with no bubble.
- `reset` has priority over `char` on the same edge, including `reset` asserted mid-record. The record is discarded and no output is produced.
- The modulo operation sits on the registered time accumulator and is combinational into `err_q`. It must close timing at the single clock.

## Structure
- `cpu_checker_pkg` holds:
  - the state enum;
  - ASCII constants (`^ @ : $ * < = # space`);
  - range constants `PC_LO` = 0x3000, `PC_HI` = 0x4fff, `ADDR_HI` = 0x2fff, `REG_MAX` = 31;
  - the `format_type` encodings.
- One sub-module, `char_classify`: combinational; outputs `is_dec`, `is_hex` and a 4-bit `nibble`. It is instantiated once.

## Test plan
- `freq`=2, stream `^123@000030fc: *00000001 <= 89abcdef#` → one cycle with `format_type`=2, `error_code`=4'b0100 (addr misaligned).
- `freq`=4, stream `^10@00003000: $31 <= 0000000a#` → `format_type`=1, `error_code`=4'b0000. Repeat with time `11` → `error_code`=4'b0001.
- `$32`, pc `00005000` → `format_type`=1, `error_code`=4'b1010.
- Syntax violations each keep `format_type`=0 for the whole stream:
  - 5 time digits;
  - uppercase `F` in the pc field;
  - a missing `=`;
  - 7 pc digits.
- `^12@000` followed by `^5@00003004:*00000000<=00000000#` with `freq`=2 → only the second record reports: `format_type`=2, `error_code`=0.
- Two records back-to-back: `format_type` pulses 2 then 1, each for exactly one cycle. `reset` asserted one cycle before `#` → no pulse.
